// File: rtl/wb_dest_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// wb_dest_scoreboard_pkg
// Shared constants and types for the writeback destination scoreboard.
//   REG_ADDR_W    : width of a register number (5 -> 32 registers)
//   NUM_REGS      : number of architectural registers
//   CNT_W_DEFAULT : default width of each outstanding-write counter
//   TOTAL_W       : width of the summed outstanding-write count
// ---------------------------------------------------------------------------
package wb_dest_scoreboard_pkg;

  localparam int REG_ADDR_W    = 5;
  localparam int NUM_REGS      = 32;
  localparam int CNT_W_DEFAULT = 2;
  localparam int TOTAL_W       = 7;

  typedef logic [REG_ADDR_W-1:0]    reg_addr_t;
  typedef logic [CNT_W_DEFAULT-1:0] cnt_t;

endpackage : wb_dest_scoreboard_pkg

// File: rtl/wb_dest_scoreboard_counter.sv
// ---------------------------------------------------------------------------
// sb_counter
// One saturating up/down counter tracking in-flight writes to a register.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc, dec   : count up / count down (both together leave it unchanged)
//   count      : current count
//   nonzero    : count != 0
//   at_max     : count == 2^CNT_W-1
// ---------------------------------------------------------------------------
module sb_counter
  import wb_dest_scoreboard_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             nonzero,
  output logic             at_max
);

  localparam logic [CNT_W-1:0] MAX_CNT = '1;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && !dec && count != MAX_CNT) begin
      count <= count + 1'b1;
    end else if (dec && !inc && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign nonzero = |count;
  assign at_max  = &count;

endmodule : sb_counter

// File: rtl/wb_dest_scoreboard.sv
// ---------------------------------------------------------------------------
// wb_dest_scoreboard
// Counts outstanding register-file writes per destination register so the
// decoder can stall on sources that still have a write in flight.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   issue_valid/issue_addr : instruction with a destination is issuing
//   issue_ready            : combinational; issue can be accepted
//   wb_valid/wb_addr       : writeback retiring to the register file
//   rs_addr/rt_addr        : source registers of the decoding instruction
//   rs_busy/rt_busy        : combinational; source has an outstanding write
//   busy_vec               : registered; bit i = counter i nonzero
//   total_out              : registered; sum of all counters
//   err                    : registered, sticky; writeback with no outstanding
// Configuration macro:
//   WB_DEST_SCOREBOARD_BYPASS_EN : a source whose last outstanding write is
//   retiring this cycle reads as not busy.
// ---------------------------------------------------------------------------
module wb_dest_scoreboard
  import wb_dest_scoreboard_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_addr,
  output logic                  issue_ready,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  output logic                  rs_busy,
  output logic                  rt_busy,
  output logic [NUM_REGS-1:0]   busy_vec,
  output logic [TOTAL_W-1:0]    total_out,
  output logic                  err
);

  logic [CNT_W-1:0]    count [NUM_REGS];
  logic [NUM_REGS-1:0] nz_vec;
  logic [NUM_REGS-1:0] max_vec;
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;
  logic                wb_accept;
  logic                wb_orphan;
  logic                issue_accept;
  logic [TOTAL_W-1:0]  total_next;

  // Register 0 is hard-wired to an idle counter; 1..31 get real counters.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (i == 0) begin : g_zero
      assign count[i]   = '0;
      assign nz_vec[i]  = 1'b0;
      assign max_vec[i] = 1'b0;
    end else begin : g_cnt
      sb_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (inc_vec[i]),
        .dec    (dec_vec[i]),
        .count  (count[i]),
        .nonzero(nz_vec[i]),
        .at_max (max_vec[i])
      );
    end
  end

  assign wb_accept = wb_valid && (wb_addr != '0) && nz_vec[wb_addr];
  assign wb_orphan = wb_valid && (wb_addr != '0) && !nz_vec[wb_addr];

  // A full counter can still take an issue when a writeback to the same
  // register frees a slot in the same cycle.
  assign issue_ready  = !(max_vec[issue_addr] && !(wb_accept && wb_addr == issue_addr));
  assign issue_accept = issue_valid && issue_ready && (issue_addr != '0);

  // NOTE: every variable gets a default at the top of always_comb so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    inc_vec    = '0;
    dec_vec    = '0;
    total_next = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      inc_vec[i] = issue_accept && (issue_addr == REG_ADDR_W'(i));
      dec_vec[i] = wb_accept && (wb_addr == REG_ADDR_W'(i));
      total_next = total_next + TOTAL_W'(count[i]);
    end
  end

`ifdef WB_DEST_SCOREBOARD_BYPASS_EN
  // The retiring write is the last one outstanding: the value is on the
  // writeback bus this cycle, so the source need not wait.
  assign rs_busy = nz_vec[rs_addr] &&
                   !(wb_accept && wb_addr == rs_addr && count[rs_addr] == CNT_W'(1));
  assign rt_busy = nz_vec[rt_addr] &&
                   !(wb_accept && wb_addr == rt_addr && count[rt_addr] == CNT_W'(1));
`else
  assign rs_busy = nz_vec[rs_addr];
  assign rt_busy = nz_vec[rt_addr];
`endif

  // Status outputs lag the counters by one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_vec  <= '0;
      total_out <= '0;
      err       <= 1'b0;
    end else begin
      busy_vec  <= nz_vec;
      total_out <= total_next;
      err       <= err | wb_orphan;
    end
  end

endmodule : wb_dest_scoreboard

// File: tb/tb_wb_dest_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_wb_dest_scoreboard
// Scoreboard bench: a driver applies one input vector per cycle, computes
// the expected outputs from an arithmetic model of per-register outstanding
// write counts, and queues them; a monitor pops and compares each cycle.
// ---------------------------------------------------------------------------
module tb_wb_dest_scoreboard;

  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_addr = '0;
  logic        issue_ready;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [4:0]  rs_addr = '0;
  logic [4:0]  rt_addr = '0;
  logic        rs_busy;
  logic        rt_busy;
  logic [31:0] busy_vec;
  logic [6:0]  total_out;
  logic        err;

  wb_dest_scoreboard dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_valid(issue_valid),
    .issue_addr (issue_addr),
    .issue_ready(issue_ready),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .rs_busy    (rs_busy),
    .rt_busy    (rt_busy),
    .busy_vec   (busy_vec),
    .total_out  (total_out),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ready;
    logic        rs_b;
    logic        rt_b;
    logic [31:0] busy;
    logic [6:0]  total;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;

  // Reference model: outstanding writes per register plus the
  // one-cycle-late status view.
  int          cnt[32];
  logic        err_m;
  logic [31:0] busy_m;
  int          total_m;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit src_busy(input int a, input bit wb_ok, input int wa);
    bit b;
    b = (a != 0) && (cnt[a] != 0);
`ifdef WB_DEST_SCOREBOARD_BYPASS_EN
    if (wb_ok && wa == a && cnt[a] == 1) b = 1'b0;
`endif
    return b;
  endfunction

  function automatic void model_clear();
    foreach (cnt[i]) cnt[i] = 0;
    err_m   = 1'b0;
    busy_m  = '0;
    total_m = 0;
  endfunction

  // One cycle: drive at the falling edge, queue expectations, advance model.
  task automatic step(input bit iv, input int ia, input bit wv, input int wa,
                      input int rs, input int rt);
    exp_t        e;
    bit          wb_ok;
    bit          rdy;
    int          sum;
    logic [31:0] nzv;
    @(negedge clk);
    issue_valid = iv;
    issue_addr  = 5'(ia);
    wb_valid    = wv;
    wb_addr     = 5'(wa);
    rs_addr     = 5'(rs);
    rt_addr     = 5'(rt);
    wb_ok   = wv && wa != 0 && cnt[wa] > 0;
    rdy     = !(cnt[ia] == MAXC && !(wb_ok && wa == ia));
    e.ready = rdy;
    e.rs_b  = src_busy(rs, wb_ok, wa);
    e.rt_b  = src_busy(rt, wb_ok, wa);
    e.busy  = busy_m;
    e.total = 7'(total_m);
    e.err   = err_m;
    exp_q.push_back(e);
    sum = 0;
    for (int i = 0; i < 32; i++) begin
      nzv[i] = (cnt[i] != 0);
      sum += cnt[i];
    end
    busy_m  = nzv;
    total_m = sum;
    if (wv && wa != 0 && cnt[wa] == 0) err_m = 1'b1;
    if (iv && rdy && ia != 0) cnt[ia]++;
    if (wb_ok) cnt[wa]--;
  endtask

  task automatic idle(input int rs, input int rt);
    step(0, 0, 0, 0, rs, rt);
  endtask

  // Reset pulse placed between edges; outputs must clear immediately.
  task automatic reset_pulse();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_busy_vec", busy_vec, 32'h0);
    check("rst_total", 32'(total_out), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_rs_busy", 32'(rs_busy), 32'h0);
    check("rst_rt_busy", 32'(rt_busy), 32'h0);
    check("rst_ready", 32'(issue_ready), 32'h1);
    model_clear();
    exp_q.delete();
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compares every queued expectation away from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("issue_ready", 32'(issue_ready), 32'(e.ready));
        check("rs_busy", 32'(rs_busy), 32'(e.rs_b));
        check("rt_busy", 32'(rt_busy), 32'(e.rt_b));
        check("busy_vec", busy_vec, e.busy);
        check("total_out", 32'(total_out), 32'(e.total));
        check("err", 32'(err), 32'(e.err));
      end
    end
  end

  initial begin
    model_clear();
    reset_pulse();

    // Idle after release: every address ready and not busy.
    for (int a = 0; a < 32; a += 4) step(1'b0, a, 1'b0, 0, a, a + 1);

    // Single issue to 5, then status one cycle after the counter.
    step(1, 5, 0, 0, 5, 0);
    idle(5, 0);
    idle(5, 6);

    // Saturate register 9, blocked 4th issue, then issue with writeback.
    repeat (3) step(1, 9, 0, 0, 9, 0);
    step(1, 9, 0, 0, 9, 9);
    step(1, 9, 1, 9, 9, 0);
    idle(9, 5);
    idle(9, 5);

    // Register 0 is never tracked.
    step(1, 0, 1, 0, 0, 0);
    idle(0, 0);
    idle(0, 0);

    // Writeback with nothing outstanding: sticky error.
    step(0, 0, 1, 12, 12, 0);
    idle(12, 0);
    idle(12, 0);

    // Last outstanding write retiring while it is being read.
    reset_pulse();
    step(1, 7, 0, 0, 0, 0);
    step(0, 0, 1, 7, 7, 7);
    idle(7, 7);

    // Build several counters, reset mid-stream, then start over.
    step(1, 3, 0, 0, 0, 0);
    step(1, 4, 0, 0, 0, 0);
    step(1, 31, 0, 0, 0, 0);
    reset_pulse();
    step(1, 3, 0, 0, 3, 4);
    idle(3, 31);
    idle(3, 31);

    // Randomised traffic concentrated on a few registers to hit saturation.
    for (int n = 0; n < 400; n++) begin
      int ia, wa;
      ia = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
      wa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
      step(bit'($urandom_range(0, 1)), ia, bit'($urandom_range(0, 1)), wa,
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      if (n == 200) reset_pulse();
    end
    idle(0, 0);
    idle(0, 0);

    @(negedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_wb_dest_scoreboard

// File: doc/wb_dest_scoreboard.md
WB_DEST_SCOREBOARD -- requirements
Module: wb_dest_scoreboard

Interface
REQ-001 Parameter CNT_W, default 2: width of the per-register outstanding-write counter; maximum count is 2^CNT_W-1.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 issue_valid  input  1  an instruction with a destination register is issuing this cycle.
REQ-005 issue_addr  input  5  destination register number from the rd/rt destination-select mux.
REQ-006 issue_ready  output  1  combinational; issue may be accepted.
REQ-007 wb_valid  input  1  a writeback to the register file retires this cycle.
REQ-008 wb_addr  input  5  register number being written back.
REQ-009 rs_addr, rt_addr  input  5 each  source register numbers of the decoding instruction.
REQ-010 rs_busy, rt_busy  output  1 each  combinational; the source has an outstanding write.
REQ-011 busy_vec  output  32  registered; bit i set when counter i is nonzero.
REQ-012 total_out  output  7  registered; sum of all counters.
REQ-013 err  output  1  registered, sticky; a writeback arrived for a register with count 0.

Function
REQ-014 Accepted issue = issue_valid && issue_ready && issue_addr != 0; it increments counter[issue_addr].
REQ-015 Accepted writeback = wb_valid && wb_addr != 0 && counter[wb_addr] != 0; it decrements counter[wb_addr].
REQ-016 Register 0 is never tracked: its counter stays 0; issue_ready = 1 for addr 0; rs_busy/rt_busy = 0 for addr 0.
REQ-017 issue_ready = 0 only when counter[issue_addr] is at maximum and no accepted writeback to the same address occurs this cycle.
REQ-018 Accepted issue and accepted writeback to the same address in one cycle: counter unchanged.
REQ-019 Accepted issue and writeback to different addresses: both applied in the same cycle.
REQ-020 Counters never wrap: no increment at maximum, no decrement at 0.
REQ-021 A writeback with wb_addr != 0 and count 0: counter unchanged, err set at the next edge, held until reset.
REQ-022 busy_vec and total_out reflect counter state one cycle after the updating edge (latency 1).
REQ-023 rs_busy = (counter[rs_addr] != 0), modified per REQ-029; rt_busy likewise.

Reset
REQ-024 While rst_n = 0: all counters 0, busy_vec = 0, total_out = 0, err = 0, asynchronously.
REQ-025 Reset asserted mid-operation discards all outstanding state; no issue or writeback is recorded at the releasing edge.
REQ-026 After release with no activity: issue_ready = 1 and rs_busy = rt_busy = 0 for every address.

Configuration
REQ-027 The macro WB_DEST_SCOREBOARD_BYPASS_EN controls same-cycle writeback bypass.
REQ-028 Without the macro: rs_busy/rt_busy are computed from the current counter only.
REQ-029 With the macro: rs_busy is forced to 0 when an accepted writeback targets rs_addr and counter[rs_addr] = 1; the same rule applies to rt_busy.

Structure
REQ-030 A shared package holds REG_ADDR_W = 5, NUM_REGS = 32, the default CNT_W and the counter typedef.
REQ-031 One sub-module, sb_counter (one saturating up/down counter with inc, dec and nonzero outputs), is instantiated 31 times for registers 1..31.

Verification
REQ-032 Reset, then issue addr 5 -> next cycle busy_vec = 32'h0000_0020, total_out = 1; rs_addr = 5 gives rs_busy = 1.
REQ-033 Issue addr 9 three times (CNT_W = 2) -> issue_ready = 0 for addr 9; wb 9 in the same cycle as a 4th issue -> issue accepted and counter stays 3.
REQ-034 Issue addr 0, wb addr 0, rs_addr = 0 -> busy_vec = 0, total_out = 0, rs_busy = 0, err = 0.
REQ-035 wb addr 12 with count 0 -> err = 1 next cycle and stays 1; counters unchanged.
REQ-036 Counter[7] = 1, wb 7 with rt_addr = 7 in the same cycle -> rt_busy = 1 without the macro, 0 with WB_DEST_SCOREBOARD_BYPASS_EN.
REQ-037 Build counters on 3, 4 and 31, then pulse rst_n low between edges -> all outputs 0 immediately; next issue of 3 gives total_out = 1.
